// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver.
// Scans NUM_DIGITS digits with a hex decoder, per-digit blanking and decimal
// point. One dark cycle is inserted at the start of every digit slot. New frames
// arrive over a valid/ready handshake and are swapped in only at the frame wrap.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS         = 4,
    parameter int DIV_COUNT          = 8,
    parameter bit ANODE_ACTIVE_LOW   = 1'b0,
    parameter bit CATHODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_blank,
    input  logic [NUM_DIGITS-1:0]   digit_dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Inactive levels of the pins, also used as XOR masks for polarity.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF   = {7{CATHODE_ACTIVE_LOW}};

    // Hex nibble to active-high segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'b1111110;
            4'h1:    hex_decode = 7'b0110000;
            4'h2:    hex_decode = 7'b1101101;
            4'h3:    hex_decode = 7'b1111001;
            4'h4:    hex_decode = 7'b0110011;
            4'h5:    hex_decode = 7'b1011011;
            4'h6:    hex_decode = 7'b1011111;
            4'h7:    hex_decode = 7'b1110000;
            4'h8:    hex_decode = 7'b1111111;
            4'h9:    hex_decode = 7'b1111011;
            4'hA:    hex_decode = 7'b1110111;
            4'hB:    hex_decode = 7'b0011111;
            4'hC:    hex_decode = 7'b1001110;
            4'hD:    hex_decode = 7'b0111101;
            4'hE:    hex_decode = 7'b1001111;
            default: hex_decode = 7'b1000111;
        endcase
    endfunction

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp_data;
    logic [NUM_DIGITS-1:0]   r_disp_blank;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_v;
    logic                    r_load_ready;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_cathode;
    logic                    r_dp;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_accept;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic                    w_dp_sel;
    logic [NUM_DIGITS-1:0]   w_anode_on;
    logic [6:0]              w_seg_on;
    logic                    w_dp_on;

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
    assign w_accept   = load_valid && r_load_ready;
    assign w_nib      = r_disp_data[4*r_idx +: 4];
    assign w_blank    = r_disp_blank[r_idx];
    assign w_dp_sel   = r_disp_dp[r_idx];

    // Slot counter and digit index; the index advances at each slot end.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Handshake: capture into the pending buffer, promote it only at the frame wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_data  <= '0;
            r_pend_blank <= '0;
            r_pend_dp    <= '0;
            r_pend_v     <= 1'b0;
            r_load_ready <= 1'b1;
            r_disp_data  <= '0;
            r_disp_blank <= '1;
            r_disp_dp    <= '0;
        end else begin
            // Ready implies nothing is pending, so accept and promote never coincide.
            if (w_accept) begin
                r_pend_data  <= digit_data;
                r_pend_blank <= digit_blank;
                r_pend_dp    <= digit_dp;
                r_pend_v     <= 1'b1;
                r_load_ready <= 1'b0;
            end else if (w_wrap && r_pend_v) begin
                r_disp_data  <= r_pend_data;
                r_disp_blank <= r_pend_blank;
                r_disp_dp    <= r_pend_dp;
                r_pend_v     <= 1'b0;
                r_load_ready <= 1'b1;
            end
        end
    end

    // Active-high view of what the current slot position should show.
    always_comb begin
        w_anode_on = '0;
        w_seg_on   = '0;
        w_dp_on    = 1'b0;
        if (r_cnt != '0) begin
            w_anode_on[r_idx] = 1'b1;
            if (!w_blank) begin
                w_seg_on = hex_decode(w_nib);
                w_dp_on  = w_dp_sel;
            end
        end
    end

    // Registered pin drivers with polarity applied, plus the frame wrap pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_anode      <= ANODE_OFF;
            r_cathode    <= SEG_OFF;
            r_dp         <= CATHODE_ACTIVE_LOW;
            r_frame_done <= 1'b0;
        end else begin
            r_anode      <= w_anode_on ^ ANODE_OFF;
            r_cathode    <= w_seg_on ^ SEG_OFF;
            r_dp         <= w_dp_on ^ CATHODE_ACTIVE_LOW;
            r_frame_done <= w_wrap;
        end
    end

    assign load_ready = r_load_ready;
    assign anode      = r_anode;
    assign cathode    = r_cathode;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with default parameters
// (4 digits, 8 cycles per slot, active-high anodes, active-low cathodes).
module tb_seven_seg_scan_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] digit_data = '0;
    logic [3:0]  digit_blank = '0;
    logic [3:0]  digit_dp = '0;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected display contents, pending frame and position since the last wrap.
    logic [15:0] e_data;
    logic [3:0]  e_blank;
    logic [3:0]  e_dp;
    logic [15:0] p_data;
    logic [3:0]  p_blank;
    logic [3:0]  p_dp;
    logic        p_v;
    int          fpos;

    localparam logic [6:0] SEG [0:15] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seven_seg_scan_driver #(
        .NUM_DIGITS(4),
        .DIV_COUNT(8),
        .ANODE_ACTIVE_LOW(1'b0),
        .CATHODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .digit_data(digit_data),
        .digit_blank(digit_blank),
        .digit_dp(digit_dp),
        .anode(anode),
        .cathode(cathode),
        .dp(dp),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run n edges. mode 0: no offer, 1: pulse offer on the first edge,
    // 2: offer on the first edge then keep load_valid high with junk data,
    // 3: offer only on the wrap edge.
    task automatic run(input int n, input int mode, input logic [15:0] nd,
                       input logic [3:0] nb, input logic [3:0] ndp);
        for (int i = 0; i < n; i++) begin
            int          slot;
            int          ph;
            int          pos0;
            bit          wrap;
            bit          acc;
            logic [3:0]  ea;
            logic [6:0]  ec;
            logic        ed;
            if ((mode == 1 || mode == 2) && i == 0) begin
                load_valid = 1'b1; digit_data = nd; digit_blank = nb; digit_dp = ndp;
            end else if (mode == 3 && fpos == 31) begin
                load_valid = 1'b1; digit_data = nd; digit_blank = nb; digit_dp = ndp;
            end else begin
                load_valid  = (mode == 2);
                digit_data  = 16'($urandom);
                digit_blank = 4'($urandom);
                digit_dp    = 4'($urandom);
            end
            pos0 = fpos;
            slot = fpos / 8;
            ph   = fpos % 8;
            wrap = (fpos == 31);
            acc  = load_valid && !p_v;
            if (ph == 0) begin
                ea = 4'b0000; ec = 7'b1111111; ed = 1'b1;
            end else begin
                ea = 4'b0001 << slot;
                if (e_blank[slot]) begin
                    ec = 7'b1111111; ed = 1'b1;
                end else begin
                    ec = ~SEG[e_data[slot*4 +: 4]];
                    ed = ~e_dp[slot];
                end
            end
            @(posedge clock); #1;
            if (wrap && p_v) begin
                e_data = p_data; e_blank = p_blank; e_dp = p_dp; p_v = 1'b0;
            end
            if (acc) begin
                p_data = digit_data; p_blank = digit_blank; p_dp = digit_dp; p_v = 1'b1;
            end
            fpos = wrap ? 0 : fpos + 1;
            chk($sformatf("anode@%0d", pos0), 32'(anode), 32'(ea));
            chk($sformatf("cathode@%0d", pos0), 32'(cathode), 32'(ec));
            chk($sformatf("dp@%0d", pos0), 32'(dp), 32'(ed));
            chk($sformatf("load_ready@%0d", pos0), 32'(load_ready), 32'(!p_v));
            chk($sformatf("frame_done@%0d", pos0), 32'(frame_done), 32'(wrap));
        end
        load_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_anode"}, 32'(anode), 32'h0);
        chk({tag, "_cathode"}, 32'(cathode), 32'h7F);
        chk({tag, "_dp"}, 32'(dp), 32'h1);
        chk({tag, "_ready"}, 32'(load_ready), 32'h1);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        int first_done;
        e_data = '0; e_blank = 4'hF; e_dp = '0;
        p_data = '0; p_blank = '0; p_dp = '0; p_v = 1'b0;
        fpos = 0;

        // Reset held for three cycles.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk_reset_state("reset");
        end
        reset = 1'b0;

        // First frame after reset: all digits blank, frame_done on the 32nd edge.
        first_done = 0;
        for (int c = 1; c <= 32; c++) begin
            run(1, 0, '0, '0, '0);
            if (frame_done && first_done == 0) first_done = c;
        end
        chk("first_frame_done_cycle", 32'(first_done), 32'd32);

        // Offer 0x4321; it is shown only from the frame after the next wrap.
        run(32, 1, 16'h4321, 4'b0000, 4'b0000);

        // Scan order and codes for 1,2,3,4 with hand-written pin values.
        run(2, 1, 16'h3210, 4'b0000, 4'b0000);
        chk("d0_anode", 32'(anode), 32'b0001);
        chk("d0_cath", 32'(cathode), 32'b1001111);
        run(8, 0, '0, '0, '0);
        chk("d1_anode", 32'(anode), 32'b0010);
        chk("d1_cath", 32'(cathode), 32'b0010010);
        run(8, 0, '0, '0, '0);
        chk("d2_anode", 32'(anode), 32'b0100);
        chk("d2_cath", 32'(cathode), 32'b0000110);
        run(8, 0, '0, '0, '0);
        chk("d3_anode", 32'(anode), 32'b1000);
        chk("d3_cath", 32'(cathode), 32'b1001100);
        run(6, 0, '0, '0, '0);

        // Full hex table over four frames; load_valid held high across frames.
        run(32, 2, 16'h7654, 4'b0000, 4'b0000);
        run(32, 2, 16'hBA98, 4'b0000, 4'b0000);
        run(32, 1, 16'hFEDC, 4'b0000, 4'b0000);
        run(32, 0, '0, '0, '0);

        // Accept exactly on the wrap edge: applied one frame later.
        run(32, 3, 16'h5A5A, 4'b0000, 4'b1010);
        run(32, 1, 16'hDEAD, 4'b0000, 4'b0000);
        run(32, 1, 16'h8888, 4'b0100, 4'b0001);

        // Blanked digit 2 keeps its anode; digit 0 shows its dp.
        run(2, 0, '0, '0, '0);
        chk("dp_d0_anode", 32'(anode), 32'b0001);
        chk("dp_d0_cath", 32'(cathode), 32'b0000000);
        chk("dp_d0_dp", 32'(dp), 32'h0);
        run(16, 0, '0, '0, '0);
        chk("blank_d2_anode", 32'(anode), 32'b0100);
        chk("blank_d2_cath", 32'(cathode), 32'b1111111);
        chk("blank_d2_dp", 32'(dp), 32'h1);
        run(14, 0, '0, '0, '0);

        // Reset at idx=2, cnt=5 with a frame pending.
        run(21, 1, 16'h1234, 4'b0000, 4'b1111);
        reset = 1'b1;
        @(posedge clock); #1;
        chk_reset_state("midreset");
        reset = 1'b0;
        e_data = '0; e_blank = 4'hF; e_dp = '0; p_v = 1'b0; fpos = 0;
        run(32, 0, '0, '0, '0);
        run(32, 0, '0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
